// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
// The index helper is used by both the selector and the pointer update.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int BURST_W        = 4;
  localparam int ID_W           = 3;

  // (base + off) mod n, assuming base < n and off < n
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int off, input int n);
    int sum;
    sum = int'(base) + off;
    if (sum >= n) sum = sum - n;
    return ID_W'(sum);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Combinational round-robin search: first set bit of req at or above
// start, wrapping around the requester vector.
module rr_select
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic               any_valid,
  output logic [ID_W-1:0]    index
);

  logic [NUM_REQ-1:0] rotated;

  // rotated[k] is the request of the k-th candidate in search order
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rotated[gi] = |(req & (NUM_REQ'(1) << wrap_idx(start, gi, NUM_REQ)));
  end

  always_comb begin
    any_valid = |rotated;
    index     = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) index = wrap_idx(start, k, NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// with bounded bursts and one arbitration bubble per grant.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = DEFAULT_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  input  logic                      fifo_full,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  state_t               state_reg;
  state_t               state_next;
  logic [ID_W-1:0]      owner_reg;
  logic [ID_W-1:0]      rr_ptr_reg;
  logic [BURST_W-1:0]   burst_cnt_reg;

  logic                 sel_any;
  logic [ID_W-1:0]      sel_index;
  logic                 owner_valid;
  logic [DATA_W-1:0]    owner_data;
  logic                 transfer;
  logic                 last_beat;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req       (req_valid),
    .start     (rr_ptr_reg),
    .any_valid (sel_any),
    .index     (sel_index)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_reg == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer  = (state_reg == GRANT) && owner_valid && !fifo_full;
  assign last_beat = transfer && (burst_cnt_reg == BURST_W'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel_any) state_next = GRANT;
      GRANT:   if (!owner_valid || last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      burst_cnt_reg <= '0;
      if (sel_any) owner_reg <= sel_index;
    end else begin
      if (transfer) burst_cnt_reg <= burst_cnt_reg + 1'b1;
      // pointer moves past the owner whenever its grant ends
      if (state_next == IDLE) rr_ptr_reg <= wrap_idx(owner_reg, 1, NUM_REQ);
    end
  end

  always_comb begin
    busy       = (state_reg == GRANT);
    grant_id   = owner_reg;
    fifo_wr_en = transfer;
    fifo_data  = transfer ? owner_data : '0;
    req_ready  = transfer ? (NUM_REQ'(1) << owner_reg) : '0;
  end

endmodule
